// File: rtl/CONFIG.sv
// CONFIG: shared audio configuration constants for the synth datapath.
package CONFIG;
    localparam int AUDIO_BIT_WIDTH    = 24;
    localparam int AUDIO_CLOCK        = 16_934_400;
    localparam int AUDIO_SAMPLE_RATE  = 44_100;
    localparam int I2S_SLOT_WIDTH     = 32;
    localparam int I2S_MCLK_PER_BCLK  = 6;
    localparam int I2S_BCLK_PER_FRAME = 64;
    localparam int I2S_DIV_W          = $clog2(I2S_MCLK_PER_BCLK);
    localparam int I2S_BIT_W          = $clog2(I2S_BCLK_PER_FRAME);
    localparam int I2S_SLOT_W         = $clog2(I2S_SLOT_WIDTH);
endpackage

// File: rtl/i2s_bit_timer.sv
// i2s_bit_timer: MCLK divider and frame bit counter producing BCLK and the frame strobes.
module i2s_bit_timer
    import CONFIG::*;
(
    input  logic                  clock_16_934_400,
    input  logic                  reset_l,
    output logic                  o_bclk,
    output logic                  o_lrclk_next,
    output logic [I2S_SLOT_W-1:0] o_slot_next,
    output logic                  o_fall_evt,
    output logic                  o_frame_load
);
    logic [I2S_DIV_W-1:0] r_div_cnt, w_div_next;
    logic [I2S_BIT_W-1:0] r_bit_idx, w_bit_next;
    logic                 r_bclk;

    always_comb begin
        o_fall_evt   = r_div_cnt == I2S_DIV_W'(I2S_MCLK_PER_BCLK - 1);
        o_frame_load = o_fall_evt && (&r_bit_idx);
        w_div_next   = o_fall_evt ? '0 : r_div_cnt + 1'b1;
        w_bit_next   = r_bit_idx + I2S_BIT_W'(o_fall_evt);
        o_lrclk_next = w_bit_next[I2S_BIT_W-1];
        o_slot_next  = w_bit_next[I2S_SLOT_W-1:0];
    end

    // BCLK is registered from the next divider value so it stays aligned with div_cnt
    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_bit_idx <= w_bit_next;
            r_bclk    <= w_div_next >= I2S_DIV_W'(I2S_MCLK_PER_BCLK / 2);
        end
    end

    assign o_bclk = r_bclk;
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serializes stereo PCM pairs onto an I2S link for the audio DAC.
module i2s_transmitter
    import CONFIG::*;
#(
    parameter int AUDIO_BIT_WIDTH = CONFIG::AUDIO_BIT_WIDTH
) (
    input  logic                       clock_16_934_400,
    input  logic                       reset_l,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic                       mclk,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata,
    output logic                       underrun
);
    localparam int W = AUDIO_BIT_WIDTH;
    localparam logic [I2S_SLOT_W:0] W_SLOT = (I2S_SLOT_W + 1)'(W);

    if (AUDIO_CLOCK != AUDIO_SAMPLE_RATE * I2S_MCLK_PER_BCLK * I2S_BCLK_PER_FRAME) begin : g_clock_check
        $error("AUDIO_CLOCK must equal AUDIO_SAMPLE_RATE * MCLK_PER_BCLK * BCLK_PER_FRAME");
    end
    if (W < 1 || W > I2S_SLOT_WIDTH) begin : g_width_check
        $error("AUDIO_BIT_WIDTH out of range 1..32");
    end

    logic                  w_bclk, w_lrclk_next, w_fall_evt, w_frame_load;
    logic [I2S_SLOT_W-1:0] w_slot_next;
    logic                  w_transfer, w_sdata_next;
    logic [W-1:0]          w_word, w_shift;
    logic [W-1:0]          r_buf_l, r_buf_r, r_act_l, r_act_r;
    logic                  r_empty, r_lrclk, r_sdata, r_underrun;

    i2s_bit_timer u_timer (
        .clock_16_934_400 (clock_16_934_400),
        .reset_l          (reset_l),
        .o_bclk           (w_bclk),
        .o_lrclk_next     (w_lrclk_next),
        .o_slot_next      (w_slot_next),
        .o_fall_evt       (w_fall_evt),
        .o_frame_load     (w_frame_load)
    );

    // Slot 0 carries the one-bit I2S delay; slots past the word width are zero pad
    always_comb begin
        w_transfer   = sample_valid && r_empty;
        w_word       = w_lrclk_next ? r_act_r : r_act_l;
        w_shift      = w_word >> (W_SLOT - {1'b0, w_slot_next});
        w_sdata_next = (w_slot_next != '0) && ({1'b0, w_slot_next} <= W_SLOT) && w_shift[0];
    end

    always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
        if (!reset_l) begin
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_act_l    <= '0;
            r_act_r    <= '0;
            r_empty    <= 1'b1;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_load && r_empty;
            if (w_frame_load && !r_empty) begin
                r_act_l <= r_buf_l;
                r_act_r <= r_buf_r;
            end
            if (w_transfer) begin
                r_buf_l <= sample_left;
                r_buf_r <= sample_right;
            end
            r_empty <= w_transfer ? 1'b0 : (r_empty || w_frame_load);
            if (w_fall_evt) begin
                r_lrclk <= w_lrclk_next;
                r_sdata <= w_sdata_next;
            end
        end
    end

    assign mclk         = clock_16_934_400;
    assign bclk         = w_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;
    assign sample_ready = r_empty;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: scoreboard bench; a DAC-side monitor rebuilds frames and checks them against queued expectations.
module tb_i2s_transmitter;
    logic        clk = 1'b0;
    logic        reset_l;
    logic [23:0] sample_left, sample_right;
    logic        sample_valid;
    logic        sample_ready, mclk, bclk, lrclk, sdata, underrun;

    always #5 clk = ~clk;

    i2s_transmitter dut (
        .clock_16_934_400 (clk),
        .reset_l          (reset_l),
        .sample_left      (sample_left),
        .sample_right     (sample_right),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .mclk             (mclk),
        .bclk             (bclk),
        .lrclk            (lrclk),
        .sdata            (sdata),
        .underrun         (underrun)
    );

    int          total = 0, bad = 0;
    int          c;
    logic        full, last_xfer, exp_und;
    logic [23:0] bl, br, cl, cr;
    logic [47:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, c);
        end
    endtask

    function automatic logic [63:0] mk_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f = '0;
        for (int s = 1; s <= 24; s++) begin
            f[63-s] = l[24-s];
            f[31-s] = r[24-s];
        end
        return f;
    endfunction

    // Reference model: one posedge per call; frame loads every 384 clocks after release
    task automatic step();
        logic pf;
        @(posedge clk);
        pf = full;
        c++;
        exp_und = (c % 384 == 0) && !pf;
        if (c % 384 == 0) begin
            if (pf) begin
                cl = bl;
                cr = br;
                full = 1'b0;
            end
            exp_q.push_back({cl, cr});
        end
        last_xfer = sample_valid && !pf;
        if (last_xfer) begin
            bl = sample_left;
            br = sample_right;
            full = 1'b1;
        end
        #1;
        chk("bclk", bclk, (c % 6) >= 3);
        chk("lrclk", lrclk, ((c / 6) % 64) >= 32);
        chk("underrun", underrun, exp_und);
        chk("sample_ready", sample_ready, !full);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic feed(input logic [23:0] l, input logic [23:0] r);
        int g = 0;
        sample_left = l;
        sample_right = r;
        sample_valid = 1'b1;
        do begin
            step();
            g++;
        end while (!last_xfer && g < 1000);
        sample_valid = 1'b0;
        if (!last_xfer) begin
            total++;
            bad++;
            $display("FAIL feed_timeout got=no transfer want=transfer");
        end
    endtask

    task automatic model_reset();
        c = 0;
        full = 1'b0;
        last_xfer = 1'b0;
        exp_und = 1'b0;
        bl = '0; br = '0; cl = '0; cr = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", sample_ready, 1);
    endtask

    task automatic release_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset_l = 1'b1;
        exp_q.push_back('0);
    endtask

    // Monitor: acts like the DAC, sampling sdata on each BCLK rise
    initial begin
        int          p = 0;
        logic [63:0] f = '0;
        logic        pb = 1'b0;
        logic [47:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_l) begin
                p = 0;
                pb = 1'b0;
            end else begin
                if (bclk && !pb) begin
                    f[63-p] = sdata;
                    if (p == 63) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL frame_queue got=empty want=entry");
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame", f, mk_frame(e[47:24], e[23:0]));
                            chk("mclk", mclk, clk);
                        end
                    end
                    p = (p + 1) % 64;
                end
                pb = bclk;
            end
        end
    end

    initial begin
        int g;
        reset_l = 1'b0;
        sample_valid = 1'b0;
        sample_left = '0;
        sample_right = '0;
        model_reset();
        release_reset();
        run(800);
        feed(24'h800001, 24'h7FFFFF);
        run(900);
        sample_left = 24'($urandom);
        sample_right = 24'($urandom);
        sample_valid = 1'b1;
        repeat (5 * 384) begin
            step();
            if (last_xfer) begin
                sample_left = 24'($urandom);
                sample_right = 24'($urandom);
            end
        end
        sample_valid = 1'b0;
        feed(24'h123456, 24'($urandom));
        run(3 * 384);
        while (c % 384 != 383) step();
        sample_left = 24'h0F0F0F;
        sample_right = 24'hF0F0F0;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        run(800);
        repeat (6 * 384) begin
            if (last_xfer) sample_valid = 1'b0;
            if (!sample_valid && $urandom_range(0, 299) == 0) begin
                sample_left = 24'($urandom);
                sample_right = 24'($urandom);
                sample_valid = 1'b1;
            end
            step();
        end
        sample_valid = 1'b0;
        feed(24'hABCDEF, 24'hFFFFFF);
        g = 0;
        while (!(c % 384 == 240 && cl == 24'hABCDEF) && g < 2000) begin
            step();
            g++;
        end
        if (g >= 2000) begin
            total++;
            bad++;
            $display("FAIL reset_point_timeout got=%0d want=<2000", g);
        end
        #2;
        reset_l = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        release_reset();
        run(900);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
